// File: rtl/ro_meter_pkg.sv
// ---------------------------------------------------------------------------
// ro_meter_pkg
// Shared definitions for the ring-oscillator frequency meter.
//   state_e          : measurement sequencer states
//   SYNC_STAGES_DEF  : default depth of the RO_IN synchroniser
//   SETTLE_CYC_DEF   : default ring settle time in CLK cycles
// ---------------------------------------------------------------------------
package ro_meter_pkg;

    // Sequencer states; BUSY is high whenever the meter is not parked in IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_CYC_DEF  = 4;

endpackage

// File: rtl/ro_sync_edge.sv
// ---------------------------------------------------------------------------
// ro_sync_edge
// Brings the free-running ring tap into the CLK domain through a chain of
// SYNC_STAGES flops and flags a rising edge of the synchronised level.
//   clk_i   in   CLK domain clock, rising edge
//   rst_ni  in   asynchronous active-low clear of all flops
//   async_i in   ring tap, asynchronous to clk_i
//   rise_o  out  one-cycle flag: synchronised level is 1 and was 0 last cycle
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module ro_sync_edge
    import ro_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift chain: bit 0 is the metastability-catching flop, the MSB is the
    // settled level. prev_q remembers last cycle's settled level for the
    // edge detector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// ---------------------------------------------------------------------------
// ro_freq_meter
// Ring-oscillator frequency meter. On START it releases the ring, waits for
// it to settle, counts synchronised rising edges of the ring tap over a
// programmable number of CLK cycles, stops the ring again and reports the
// (saturating) edge count.
//   CLK     in   clock, rising edge
//   R       in   asynchronous active-low reset
//   START   in   measurement request, only looked at while idle
//   WINDOW  in   gate length in CLK cycles, captured with START
//   RO_IN   in   ring tap, asynchronous to CLK
//   RO_STOP out  1 holds the ring stopped (forces the NOR ring output low)
//   BUSY    out  1 while a measurement is in flight, including the DONE cycle
//   DONE    out  one-cycle pulse when COUNT/OVF have just been updated
//   COUNT   out  rising edges seen in the last window, saturating
//   OVF     out  1 if the last window saturated COUNT
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             RO_IN,
    output logic             RO_STOP,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    // Timer value seen in the last SETTLE cycle. With an empty window nothing
    // is ever counted, so the sequencer skips the final settle cycle and
    // jumps to REPORT one cycle early.
    localparam logic [WIN_W-1:0] SETTLE_LAST       = WIN_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST_EMPTY = WIN_W'(SETTLE_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_MAX           = '1;

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WIN_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               ovf_flag_q, ovf_flag_d;

    logic               ro_stop_q, ro_stop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               edge_rise;

    ro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (CLK),
        .rst_ni  (R),
        .async_i (RO_IN),
        .rise_o  (edge_rise)
    );

    // State register. RO_STOP resets to 1 through the async clear, so the
    // ring is stopped the moment R falls, without waiting for CLK.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q    <= IDLE;
            win_q      <= '0;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            ovf_flag_q <= 1'b0;
            ro_stop_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_flag_q <= ovf_flag_d;
            ro_stop_q  <= ro_stop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic. One timer serves both the settle delay and the gate
    // window; it is cleared on entry to each phase. The edge counter sticks
    // at all-ones and any further edge raises the internal overflow flag.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        ovf_flag_d = ovf_flag_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = SETTLE;
                    win_d      = WINDOW;
                    timer_d    = '0;
                    edge_cnt_d = '0;
                    ovf_flag_d = 1'b0;
                end
            end

            SETTLE: begin
                timer_d = timer_q + 1'b1;
                if (win_q == '0) begin
                    if (timer_q == SETTLE_LAST_EMPTY) begin
                        state_d = REPORT;
                    end
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    timer_d = '0;
                end
            end

            MEASURE: begin
                timer_d = timer_q + 1'b1;
                if (edge_rise) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_flag_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                if (timer_q == win_q - 1'b1) begin
                    state_d = REPORT;
                end
            end

            REPORT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic, registered. The ring runs only while settling or
    // measuring. BUSY also spans the cycle after REPORT so it is still high
    // while DONE is presented. COUNT/OVF are loaded on leaving REPORT and
    // otherwise hold.
    always_comb begin
        ro_stop_d = !((state_d == SETTLE) || (state_d == MEASURE));
        busy_d    = (state_d != IDLE) || (state_q != IDLE);
        done_d    = (state_q == REPORT);
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (state_q == REPORT) begin
            count_d = edge_cnt_q;
            ovf_d   = ovf_flag_q;
        end
    end

    assign RO_STOP = ro_stop_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign COUNT   = count_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_meter
// Scoreboard bench for ro_freq_meter. Stimulus pushes the expected DONE cycle,
// COUNT range and OVF for each accepted START; per-DUT monitors pop and
// compare whenever DONE is seen. Two instances: A with the default 16-bit
// counter, B with a 4-bit counter for the saturation cases.
// Cycle numbering: START sampled at edge k; "cycle k+n" is the clock period
// that follows edge k+n-1, observed at its falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ro_freq_meter;

    typedef struct {
        int doneCyc;
        int cntMin;
        int cntMax;
        int ovf;
    } expT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        startA, startB;
    logic [15:0] winA, winB;
    logic        roIn;
    logic        roStopA, busyA, doneA, ovfA;
    logic [15:0] countA;
    logic        roStopB, busyB, doneB, ovfB;
    logic [3:0]  countB;

    int   checks = 0;
    int   errors = 0;
    int   edgeCnt = 0;
    int   halfPeriod = 5;
    expT  qA[$];
    expT  qB[$];

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2), .SETTLE_CYC(4)) dutA (
        .CLK(clk), .R(rstN), .START(startA), .WINDOW(winA), .RO_IN(roIn),
        .RO_STOP(roStopA), .BUSY(busyA), .DONE(doneA), .COUNT(countA), .OVF(ovfA)
    );

    ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2), .SETTLE_CYC(4)) dutB (
        .CLK(clk), .R(rstN), .START(startB), .WINDOW(winB), .RO_IN(roIn),
        .RO_STOP(roStopB), .BUSY(busyB), .DONE(doneB), .COUNT(countB), .OVF(ovfB)
    );

    // Free-running (externally divided) ring tap: halfPeriod CLK cycles high,
    // halfPeriod low, changing on falling edges.
    initial begin
        roIn = 1'b0;
        forever begin
            repeat (halfPeriod) @(negedge clk);
            roIn = ~roIn;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Monitor for instance A.
    always @(negedge clk) begin
        if (doneA === 1'b1) begin
            if (qA.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDoneA: DONE=1 in cycle %0d, expected 0", edgeCnt + 1);
            end else begin
                expT e;
                e = qA.pop_front();
                checkOutput("doneCycleA", edgeCnt + 1, e.doneCyc);
                checkRange("countA", int'(countA), e.cntMin, e.cntMax);
                checkOutput("ovfA", int'(ovfA), e.ovf);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (doneB === 1'b1) begin
            if (qB.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDoneB: DONE=1 in cycle %0d, expected 0", edgeCnt + 1);
            end else begin
                expT e;
                e = qB.pop_front();
                checkOutput("doneCycleB", edgeCnt + 1, e.doneCyc);
                checkRange("countB", int'(countB), e.cntMin, e.cntMax);
                checkOutput("ovfB", int'(ovfB), e.ovf);
            end
        end
    end

    // Issue one START (sampled at edge k) and push the hand-computed result.
    task automatic applyStimulus(input bit useB, input int win, input int doneOfs,
                                 input int cntMin, input int cntMax, input int ovf,
                                 output int k);
        expT e;
        @(negedge clk);
        k = edgeCnt + 1;
        e.doneCyc = k + doneOfs;
        e.cntMin  = cntMin;
        e.cntMax  = cntMax;
        e.ovf     = ovf;
        if (useB) begin
            startB = 1'b1;
            winB   = 16'(win);
            qB.push_back(e);
        end else begin
            startA = 1'b1;
            winA   = 16'(win);
            qA.push_back(e);
        end
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic waitIdle(input bit useB);
        int n;
        n = 0;
        @(negedge clk);
        while ((useB ? busyB : busyA) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (useB ? busyB : busyA) begin
            errors++;
            $display("[TB] FAIL idleTimeout: BUSY=1 after %0d cycles, expected 0", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic waitToEdge(input int e);
        while (edgeCnt < e) @(negedge clk);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_roStop"}, int'(roStopA), 1);
        checkOutput({tag, "_busy"},   int'(busyA),   0);
        checkOutput({tag, "_done"},   int'(doneA),   0);
        checkOutput({tag, "_count"},  int'(countA),  0);
        checkOutput({tag, "_ovf"},    int'(ovfA),    0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        rstN   = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        winA   = '0;
        winB   = '0;
        #1 rstN = 1'b0;

        // Reset held for 3 cycles while the ring tap toggles.
        repeat (3) begin
            @(negedge clk);
            checkResetA("reset");
            checkOutput("reset_roStopB", int'(roStopB), 1);
        end
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Period 10, window 100: DONE at k+106, ~10 edges, ring enabled k+1..k+104.
        halfPeriod = 5;
        applyStimulus(1'b0, 100, 106, 9, 11, 0, k);
        for (int c = k + 1; c <= k + 108; c++) begin
            if (c > k + 1) @(negedge clk);
            checkOutput("roStopWindow", int'(roStopA), (c <= k + 104) ? 0 : 1);
            checkOutput("busyWindow",   int'(busyA),   (c <= k + 106) ? 1 : 0);
        end
        waitIdle(1'b0);

        // Empty window: REPORT straight after SETTLE, DONE at k+5, nothing counted.
        applyStimulus(1'b0, 0, 5, 0, 0, 0, k);
        waitIdle(1'b0);

        // 4-bit counter, period 4: 25 edges in 100 cycles saturate at 15 with OVF.
        halfPeriod = 2;
        applyStimulus(1'b1, 100, 106, 15, 15, 1, k);
        waitIdle(1'b1);
        // Window 20 at period 4: exactly 5 edges, OVF cleared.
        applyStimulus(1'b1, 20, 26, 5, 5, 0, k);
        waitIdle(1'b1);

        // START re-pulsed at k+3 and k+50 with new WINDOW values: ignored.
        halfPeriod = 5;
        applyStimulus(1'b0, 100, 106, 9, 11, 0, k);
        waitToEdge(k + 2);
        startA = 1'b1;
        winA   = 16'd7;
        @(negedge clk);
        startA = 1'b0;
        waitToEdge(k + 49);
        startA = 1'b1;
        winA   = 16'd3;
        @(negedge clk);
        startA = 1'b0;
        waitIdle(1'b0);

        // Reset mid-MEASURE: RO_STOP rises with no clock edge, outputs clear.
        applyStimulus(1'b0, 100, 106, 9, 11, 0, k);
        waitToEdge(k + 40);
        checkOutput("preAbort_roStop", int'(roStopA), 0);
        #2 rstN = 1'b0;
        qA.delete();
        qB.delete();
        #1;
        checkResetA("abort");
        repeat (3) @(negedge clk);
        checkResetA("abortHeld");
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 100, 106, 9, 11, 0, k);
        waitIdle(1'b0);

        // Every pushed expectation must have been consumed by a DONE.
        checkOutput("pendingA", qA.size(), 0);
        checkOutput("pendingB", qB.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
